// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states, lane geometry
// and the acceptance-time legality check.
package lsu_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned DATA_W    = NUM_LANES * BYTE_W;

    localparam logic [LANE_W-1:0] LANE_0 = 2'd0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Opcode/alignment legality; the range check lives with the address math.
    function automatic logic access_err(input logic is_store, input logic [2:0] f3,
                                        input logic [LANE_W-1:0] lane);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_BU:   err = is_store;
            F3_H:    err = lane[0];
            F3_HU:   err = is_store | lane[0];
            F3_W:    err = (lane != LANE_0);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: sign/zero-extended load extraction and store merge into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [DATA_W-1:0] i_rword,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_ext,
    output logic [DATA_W-1:0] o_merged_word
);

    logic [4:0]        w_sh;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;

    assign w_sh      = {i_lane, 3'b000};
    assign w_shifted = i_rword >> w_sh;

    always_comb begin
        w_mask        = '1;
        o_load_ext    = i_rword;
        case (i_funct3)
            F3_B: begin
                w_mask     = 32'h0000_00FF;
                o_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                w_mask     = 32'h0000_00FF;
                o_load_ext = {24'd0, w_shifted[7:0]};
            end
            F3_H: begin
                w_mask     = 32'h0000_FFFF;
                o_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                w_mask     = 32'h0000_FFFF;
                o_load_ext = {16'd0, w_shifted[15:0]};
            end
            default: begin
                w_mask     = '1;
                o_load_ext = i_rword;
            end
        endcase
        // Clear the target lanes, then drop in the low bytes of the store data.
        o_merged_word = (i_rword & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator for a word-addressed data memory;
// sub-word stores are done as read-modify-write.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_base,
    input  logic [31:0]       req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] datain,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] dataout
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LANE_W-1:0]   r_lane;
    logic [2:0]          r_funct3;
    logic                r_store;
    logic [DATA_W-1:0]   r_datain;
    logic [DATA_W-1:0]   r_rdata;

    logic [31:0]         w_ea;
    logic                w_err;
    logic                w_accept;
    logic [DATA_W-1:0]   w_load_ext;
    logic [DATA_W-1:0]   w_merged;

    assign w_ea     = req_base + req_offset;
    assign w_err    = (|w_ea[31:ADDR_W+2]) | access_err(req_store, req_funct3, w_ea[1:0]);
    assign w_accept = req_valid & (r_state == S_IDLE);

    lsu_align u_align (
        .i_funct3      (r_funct3),
        .i_lane        (r_lane),
        .i_rword       (dataout),
        .i_wdata       (r_datain),
        .o_load_ext    (w_load_ext),
        .o_merged_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state plus strobes/handshakes decoded from the registered state.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_err)                                 w_next = S_ERR;
                    else if (req_store && req_funct3 == F3_W)  w_next = S_WR;
                    else                                       w_next = S_RD;
                end
            end
            S_RD: begin
                MemRead = 1'b1;
                w_next  = r_store ? S_WR : S_RESP;
            end
            S_WR: begin
                MemWrite = 1'b1;
                w_next   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture at acceptance; read word consumed at the end of the RD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_lane   <= '0;
            r_funct3 <= '0;
            r_store  <= 1'b0;
            r_datain <= '0;
            r_rdata  <= '0;
        end else if (w_accept) begin
            r_addr   <= w_ea[ADDR_W+1:2];
            r_lane   <= w_ea[1:0];
            r_funct3 <= req_funct3;
            r_store  <= req_store;
            r_datain <= req_wdata;
            r_rdata  <= '0;
        end else if (r_state == S_RD) begin
            r_rdata  <= r_store ? '0 : w_load_ext;
            r_datain <= w_merged;
        end
    end

    assign address    = r_addr;
    assign datain     = r_datain;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboarded random/directed bench for lsu_mem_ctrl against a byte-array memory model.
module tb_lsu_mem_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NWORDS = 32;
    localparam int unsigned NBYTES = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_base = 32'd0;
    logic [31:0] req_offset = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [4:0]  address;
    logic [31:0] datain;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] dataout;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .address    (address),
        .datain     (datain),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .dataout    (dataout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: write at the edge ending the strobe cycle, combinational read.
    logic [31:0] mem_w [NWORDS];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = 5'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clk) begin
        if (MemWrite)   mem_w[address] <= datain;
        else if (pl_en) mem_w[pl_addr] <= pl_data;
    end
    assign dataout = mem_w[address];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          seen_cyc;
        int          n_rd;
        int          n_wr;
        logic [4:0]  addr;
        logic [31:0] wword;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb[NBYTES];
    int          checks = 0;
    int          errors = 0;
    bit          bp_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = 5'(w);
        pl_data = v;
        for (int k = 0; k < 4; k++) mb[4*w+k] = v[8*k +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    always @(posedge clk) begin
        #1 resp_ready = bp_hold ? 1'b0 : ($urandom % 4 != 0);
    end

    // Monitor: strobe checks against the in-flight expectation, response pop on first valid.
    bit          seen = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] hold_rdata;
    logic        hold_err;
    exp_t        e;
    always @(negedge clk) begin
        if (reset) begin
            seen   = 1'b0;
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (MemRead && MemWrite) fail_now("strobe_overlap");
            if (MemRead) begin
                rd_cnt++;
                if (q.size() == 0) fail_now("spurious_memread");
                else chk("rd_addr", 32'(address), 32'(q[0].addr));
            end
            if (MemWrite) begin
                wr_cnt++;
                if (q.size() == 0) fail_now("spurious_memwrite");
                else begin
                    chk("wr_addr", 32'(address), 32'(q[0].addr));
                    chk("wr_data", datain, q[0].wword);
                end
            end
            if (resp_valid) begin
                if (!seen) begin
                    if (q.size() == 0) fail_now("spurious_resp");
                    else begin
                        e = q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        chk("latency", 32'(cyc), 32'(e.seen_cyc));
                        chk("n_memread", 32'(rd_cnt), 32'(e.n_rd));
                        chk("n_memwrite", 32'(wr_cnt), 32'(e.n_wr));
                    end
                    hold_rdata = resp_rdata;
                    hold_err   = resp_err;
                    seen       = 1'b1;
                    rd_cnt     = 0;
                    wr_cnt     = 0;
                end else begin
                    chk("stall_rdata", resp_rdata, hold_rdata);
                    chk("stall_err", 32'(resp_err), 32'(hold_err));
                    chk("stall_req_ready", 32'(req_ready), 32'd0);
                end
                if (resp_ready) seen = 1'b0;
            end
        end
    end

    // Reference: byte-addressed little-endian memory, size/alignment rules, fixed latencies.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wdata);
        exp_t        x;
        logic [31:0] ea;
        logic [31:0] v;
        int          size;
        int          lat;
        bit          err;
        bit          got;
        ea = base + off;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        err = (size == 0) || (st && f3[2]) || (ea >= NBYTES);
        if (!err && (ea % 32'(size)) != 0) err = 1'b1;
        x.addr  = ea[6:2];
        x.rdata = 32'd0;
        x.err   = err;
        x.n_rd  = 0;
        x.n_wr  = 0;
        x.wword = 32'd0;
        lat     = 1;
        if (!err && st) begin
            for (int k = 0; k < size; k++) mb[int'(ea) + k] = wdata[8*k +: 8];
            x.n_wr  = 1;
            x.n_rd  = (size == 4) ? 0 : 1;
            x.wword = word_of(int'(ea[6:2]));
            lat     = (size == 4) ? 2 : 3;
        end else if (!err) begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(mb[int'(ea) + k]) << (8*k));
            if (f3 == 3'd0 && v >= 32'd128)   v = v - 32'd256;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            x.rdata = v;
            x.n_rd  = 1;
            lat     = 2;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wdata;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) fail_now("req_ready_timeout");
        else begin
            x.seen_cyc = cyc + lat;
            q.push_back(x);
            @(posedge clk);
        end
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_base   = $urandom;
        req_offset = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        bit          got;
        logic [2:0]  legal [5];
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        for (int w = 0; w < int'(NWORDS); w++) preload(w, $urandom);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_datain", datain, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(1'b1, 3'd2, 32'd4, 32'd0, 32'h0000_0003);
        issue(1'b0, 3'd2, 32'd4, 32'd0, 32'd0);
        wait_drain();

        preload(2, 32'h1122_3344);
        issue(1'b1, 3'd0, 32'd9, 32'd0, 32'h0000_00AB);
        issue(1'b0, 3'd0, 32'd9, 32'd0, 32'd0);
        issue(1'b0, 3'd4, 32'd9, 32'd0, 32'd0);
        wait_drain();
        chk("sb_word", mem_w[2], 32'h1122_AB44);

        preload(2, 32'h8001_ABCD);
        issue(1'b0, 3'd1, 32'd10, 32'd0, 32'd0);
        issue(1'b0, 3'd1, 32'd11, 32'd0, 32'd0);
        issue(1'b0, 3'd2, 32'h80, 32'hFFFF_FFFC, 32'd0);
        issue(1'b0, 3'd2, 32'h80, 32'd0, 32'd0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFC, 32'd8, 32'd0);
        issue(1'b1, 3'd4, 32'd8, 32'd0, 32'h55);
        issue(1'b0, 3'd7, 32'd8, 32'd0, 32'd0);
        wait_drain();

        // Held response: stall for several cycles after the response appears.
        bp_hold    = 1'b1;
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'd8, 32'd0, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) fail_now("bp_resp_timeout");
        repeat (5) @(negedge clk);
        bp_hold = 1'b0;
        wait_drain();

        // Reset during the RD cycle of a byte store.
        preload(3, 32'hCAFE_F00D);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'd0;
        req_base   = 32'd12;
        req_offset = 32'd1;
        req_wdata  = 32'h55;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) fail_now("rst_test_ready_timeout");
        e.addr = 5'd3; e.wword = 32'hCAFE_F00D; e.rdata = 32'd0; e.err = 1'b0;
        e.n_rd = 1; e.n_wr = 0; e.seen_cyc = 0;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_test_in_rd", 32'(MemRead), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_memwrite", 32'(MemWrite), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        q.delete();
        #1 reset = 1'b0;
        @(negedge clk);
        chk("postrst_req_ready", 32'(req_ready), 32'd1);
        chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("postrst_word", mem_w[3], 32'hCAFE_F00D);
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom);
            f3 = ($urandom % 10 == 0) ? 3'($urandom) : legal[$urandom % 5];
            base = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 132));
            off  = 32'($urandom_range(0, 16)) - 32'd8;
            issue(st, f3, base, off, $urandom);
        end
        wait_drain();

        for (int w = 0; w < int'(NWORDS); w++) chk("final_mem", mem_w[w], word_of(w));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives datamemory: accepts one load/store request from the pipeline and issues MemRead/MemWrite to the 32-entry word memory.
- Computes the byte address and splits it into a word index and a byte lane.
- Extracts and sign-extends sub-word loads; performs sub-word stores as read-modify-write.
- Returns one response per request; misaligned or out-of-range accesses get an error response with no memory access.

Parameters:
- ADDR_W, 5, memory word-address width (word count 2**ADDR_W).
- DATA_W, 32, data width; fixed at 32, with byte lanes 0 to 3.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others are illegal.
- req_base  in  32  base register value.
- req_offset  in  32  sign-extended immediate.
- req_wdata  in  32  store data; the low bytes are used for B/H.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- address  out  ADDR_W  word index to datamemory.
- datain  out  DATA_W  write word to datamemory.
- MemWrite  out  1  write strobe; memory writes at the rising edge ending the cycle.
- MemRead  out  1  read strobe; dataout is valid in the same cycle.
- dataout  in  DATA_W  read word from datamemory.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is synchronous and active-high, on port reset.
- Reset:
  - state=IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - MemRead=0, MemWrite=0, address=0, datain=0.
- Address computation:
  - ea = req_base + req_offset, modulo 2^32.
  - Word index = ea[ADDR_W+1:2]; lane = ea[1:0].
  - Computed and registered at acceptance (req_valid & req_ready).
- Error, checked at acceptance:
  - ea[31:ADDR_W+2] != 0.
  - H/HU with lane==3, or lane odd.
  - W with lane != 0.
  - Illegal funct3, or store with funct3 in {100, 101}.
- States:
  - IDLE: on acceptance, go to ERR if error, else WR if W store, else RD.
  - RD, 1 cycle: MemRead=1, address=index. Register dataout at the edge. Load goes to RESP; sub-word store goes to WR.
  - WR, 1 cycle: MemWrite=1, address=index, datain = merged word (SB replaces lane byte, SH replaces lanes {lane+1, lane}, SW whole word). Go to RESP.
  - ERR: same as RESP with resp_err=1; no strobe is ever asserted.
  - RESP: resp_valid=1 held stable until resp_ready; then go to IDLE.
- Strobes:
  - MemRead and MemWrite are never both high.
  - Both are decoded from the registered state, so they are glitch-free.
- Load extraction:
  - B sign-extends the lane byte; BU zero-extends it.
  - H/HU do the same for the halfword at lanes {lane+1, lane}.
  - W passes the word through.
- Latency from the acceptance edge:
  - Load: 2 cycles to resp_valid.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: req_ready returns 1 in the cycle after the response handshake; no overlap of requests.
- resp_valid with resp_ready stalled: state, data and memory are all unchanged; no memory re-access.
- Reset mid-operation:
  - The WR cycle's write already presented completes at that edge.
  - All strobes are 0 and state is IDLE from the next cycle.
  - A pending response is discarded.
- Inputs are ignored outside IDLE; req_* are don't-care when req_valid=0.

Decomposition:
- lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - 3-bit state encoding (S_IDLE, S_RD, S_WR, S_RESP, S_ERR).
  - Lane constants.
- Sub-module lsu_align, combinational:
  - Inputs: funct3, lane, rword, wdata.
  - Outputs: load_ext and merged_word.
  - The FSM stays in lsu_mem_ctrl.

Test Plan:
- Word store then load:
  - SW base=4, off=0, wdata=0x00000003 gives a MemWrite pulse with address=1, datain=3, then resp_err=0.
  - LW at the same address gives resp_rdata=0x00000003, two cycles after acceptance.
- Byte RMW:
  - Preload word 2 = 0x11223344.
  - SB ea=9, wdata=0xAB: RD then WR of 0x1122AB44.
  - LB ea=9 gives 0xFFFFFFAB; LBU gives 0x000000AB.
- Halfword:
  - LH ea=10 on 0x8001ABCD gives 0xFFFF8001.
  - LH ea=11 gives resp_err=1 after 1 cycle with no strobe.
- Range and offset:
  - base=0x80, off=-4 gives address=31, accepted.
  - base=0x80, off=0 gives resp_err=1.
  - base=0xFFFFFFFC, off=8 gives address=1, accepted.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after an LW: resp_valid and resp_rdata stay stable, MemRead pulses exactly once, and req_ready=0 throughout.
- Reset mid-SB:
  - Assert reset in the RD cycle: no MemWrite occurs, memory word is unchanged, resp_valid=0, and req_ready=1 the next cycle.
